fpu_host_driver: RTL and testbench

Host-side initiator for the 16-bit FPU control port. It accepts add/multiply commands on a ready/valid queue and drives the FPU request handshake (`CS`/`DIV`/`DACK`). It collects each result through the FPU output handshake (`DOV`/`DOA`) and returns results, in order, on a ready/valid result queue. It sits between a sequencer or bus bridge and the FPU top, and is the only master of the FPU's input pins.

---
 rtl/fpu_host_driver.sv | 214 +++++++++++++++++++++
 tb/tb_fpu_host_driver.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_host_driver.sv
// Host-side initiator for the 16-bit FPU control port: queues add/multiply commands,
// runs one FPU request/result handshake at a time and returns results in order.
module fpu_host_driver #(
  parameter int unsigned CMD_DEPTH = 4,
  parameter int unsigned RES_DEPTH = 4,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic        CLK,
  input  logic        RSTn,
  input  logic        CMD_VALID,
  output logic        CMD_READY,
  input  logic [15:0] CMD_A,
  input  logic [15:0] CMD_B,
  input  logic        CMD_OP,
  input  logic [2:0]  CMD_MODE,
  output logic        RES_VALID,
  input  logic        RES_READY,
  output logic [15:0] RES_DATA,
  output logic [2:0]  RES_EXC,
  output logic        RES_OP,
  output logic        RES_TIMEOUT,
  output logic        CS,
  output logic [15:0] DIN1,
  output logic [15:0] DIN2,
  output logic        OPT,
  output logic [2:0]  MODE,
  output logic        DIV,
  input  logic        DACK,
  input  logic [15:0] DOUT,
  input  logic [2:0]  EXC,
  input  logic        DOV,
  output logic        DOA,
  input  logic        ABUSY,
  input  logic        MBUSY,
  input  logic        DR,
  output logic        BUSY,
  output logic        STALE
);

  localparam int unsigned CAW   = $clog2(CMD_DEPTH);
  localparam int unsigned RAW   = $clog2(RES_DEPTH);
  localparam int unsigned CMD_W = 36;
  localparam int unsigned RES_W = 21;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RES
  } state_t;

  state_t state;

  logic [CMD_W-1:0] cmd_mem [CMD_DEPTH];
  logic [CAW-1:0]   cmd_wr;
  logic [CAW-1:0]   cmd_rd;
  logic [CAW:0]     cmd_count;
  logic [CMD_W-1:0] cmd_head;

  logic [RES_W-1:0] res_mem [RES_DEPTH];
  logic [RAW-1:0]   res_wr;
  logic [RAW-1:0]   res_rd;
  logic [RAW:0]     res_count;
  logic [RES_W-1:0] res_head;
  logic [RES_W-1:0] res_wdata;

  logic [15:0] timer;
  logic [16:0] timer_inc;
  logic        expire;
  logic        dov_live;
  logic        cmd_empty;
  logic        cmd_push;
  logic        issue;
  logic        capture;
  logic        tmo;
  logic        res_push;
  logic        res_pop;
  logic        unused_status;

  // Status inputs are informational only; BUSY is derived from local state.
  assign unused_status = ^{ABUSY, MBUSY, DR};

  // A DOV still high while DOA is being driven belongs to the result being acknowledged.
  assign dov_live  = DOV & ~DOA;
  assign timer_inc = {1'b0, timer} + 17'd1;
  assign expire    = (timer_inc >= 17'(TIMEOUT));

  assign cmd_empty = (cmd_count == '0);
  assign CMD_READY = RSTn & (cmd_count != (CAW+1)'(CMD_DEPTH));
  assign cmd_push  = CMD_VALID & CMD_READY;
  assign cmd_head  = cmd_mem[cmd_rd];

  assign issue   = (state == S_IDLE) & ~cmd_empty & (res_count < (RAW+1)'(RES_DEPTH));
  assign capture = (state == S_WAIT_RES) & dov_live;
  assign tmo     = expire & (((state == S_ISSUE) & ~DACK) | ((state == S_WAIT_RES) & ~dov_live));

  assign res_push  = capture | tmo;
  assign res_pop   = RES_VALID & RES_READY;
  assign res_wdata = capture ? {DOUT, EXC, OPT, 1'b0} : {16'h0000, 3'b000, OPT, 1'b1};

  assign res_head    = res_mem[res_rd];
  assign RES_VALID   = (res_count != '0);
  assign RES_DATA    = res_head[20:5];
  assign RES_EXC     = res_head[4:2];
  assign RES_OP      = res_head[1];
  assign RES_TIMEOUT = res_head[0];

  assign BUSY = (state != S_IDLE) | ~cmd_empty;

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      cmd_wr    <= '0;
      cmd_rd    <= '0;
      cmd_count <= '0;
    end else begin
      if (cmd_push) begin
        cmd_mem[cmd_wr] <= {CMD_A, CMD_B, CMD_OP, CMD_MODE};
        cmd_wr          <= cmd_wr + CAW'(1);
      end
      if (issue) begin
        cmd_rd <= cmd_rd + CAW'(1);
      end
      unique case ({cmd_push, issue})
        2'b10:   cmd_count <= cmd_count + (CAW+1)'(1);
        2'b01:   cmd_count <= cmd_count - (CAW+1)'(1);
        default: cmd_count <= cmd_count;
      endcase
    end
  end

  // Result storage is cleared so the head fields read zero straight out of reset.
  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      res_wr    <= '0;
      res_rd    <= '0;
      res_count <= '0;
      for (int unsigned i = 0; i < RES_DEPTH; i++) begin
        res_mem[i] <= '0;
      end
    end else begin
      if (res_push) begin
        res_mem[res_wr] <= res_wdata;
        res_wr          <= res_wr + RAW'(1);
      end
      if (res_pop) begin
        res_rd <= res_rd + RAW'(1);
      end
      unique case ({res_push, res_pop})
        2'b10:   res_count <= res_count + (RAW+1)'(1);
        2'b01:   res_count <= res_count - (RAW+1)'(1);
        default: res_count <= res_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state <= S_IDLE;
      timer <= '0;
      CS    <= 1'b0;
      DIV   <= 1'b0;
      DOA   <= 1'b0;
      STALE <= 1'b0;
      DIN1  <= '0;
      DIN2  <= '0;
      OPT   <= 1'b0;
      MODE  <= '0;
    end else begin
      CS    <= 1'b1;
      DOA   <= 1'b0;
      STALE <= 1'b0;
      if (dov_live && (state != S_WAIT_RES)) begin
        DOA   <= 1'b1;
        STALE <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (issue) begin
            DIN1  <= cmd_head[35:20];
            DIN2  <= cmd_head[19:4];
            OPT   <= cmd_head[3];
            MODE  <= cmd_head[2:0];
            DIV   <= 1'b1;
            timer <= '0;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          timer <= timer_inc[15:0];
          if (DACK) begin
            DIV   <= 1'b0;
            state <= S_WAIT_RES;
          end else if (expire) begin
            DIV   <= 1'b0;
            state <= S_IDLE;
          end
        end
        S_WAIT_RES: begin
          timer <= timer_inc[15:0];
          if (dov_live) begin
            DOA   <= 1'b1;
            state <= S_IDLE;
          end else if (expire) begin
            state <= S_IDLE;
          end
        end
        default: begin
          DIV   <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_host_driver.sv
// Directed bench for fpu_host_driver with a small reactive FPU responder.
module tb_fpu_host_driver;

  logic        CLK = 1'b0;
  logic        RSTn;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic [15:0] CMD_A;
  logic [15:0] CMD_B;
  logic        CMD_OP;
  logic [2:0]  CMD_MODE;
  logic        RES_VALID;
  logic        RES_READY;
  logic [15:0] RES_DATA;
  logic [2:0]  RES_EXC;
  logic        RES_OP;
  logic        RES_TIMEOUT;
  logic        CS;
  logic [15:0] DIN1;
  logic [15:0] DIN2;
  logic        OPT;
  logic [2:0]  MODE;
  logic        DIV;
  logic        DACK;
  logic [15:0] DOUT;
  logic [2:0]  EXC;
  logic        DOV;
  logic        DOA;
  logic        ABUSY;
  logic        MBUSY;
  logic        DR;
  logic        BUSY;
  logic        STALE;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // FPU responder controls and observations
  logic        fpu_auto = 1'b0;
  int          dack_dly = 0;
  int          dov_dly  = 5;
  logic [15:0] resp_q[$];
  logic [2:0]  resp_exc = 3'b000;
  int          issued = 0;
  int          overlap_err = 0;
  logic        m_dack = 1'b0;
  logic        m_dov  = 1'b0;
  logic [15:0] m_dout = 16'h0000;
  logic [2:0]  m_exc  = 3'b000;
  logic        man_dov = 1'b0;
  logic [15:0] man_dout = 16'h0000;

  // Negedge monitor state
  int          div_run = 0;
  int          last_div_run = 0;
  int          doa_run = 0;
  int          last_doa_run = 0;
  int          div_unstable = 0;
  int          stale_cnt = 0;
  logic [34:0] div_fields = '0;
  int          ready_low = 0;

  assign DACK = m_dack;
  assign DOV  = m_dov | man_dov;
  assign DOUT = man_dov ? man_dout : m_dout;
  assign EXC  = m_exc;

  always #5 CLK = ~CLK;

  fpu_host_driver #(
    .CMD_DEPTH(4),
    .RES_DEPTH(4),
    .TIMEOUT  (20)
  ) dut (
    .CLK(CLK), .RSTn(RSTn),
    .CMD_VALID(CMD_VALID), .CMD_READY(CMD_READY),
    .CMD_A(CMD_A), .CMD_B(CMD_B), .CMD_OP(CMD_OP), .CMD_MODE(CMD_MODE),
    .RES_VALID(RES_VALID), .RES_READY(RES_READY),
    .RES_DATA(RES_DATA), .RES_EXC(RES_EXC), .RES_OP(RES_OP), .RES_TIMEOUT(RES_TIMEOUT),
    .CS(CS), .DIN1(DIN1), .DIN2(DIN2), .OPT(OPT), .MODE(MODE),
    .DIV(DIV), .DACK(DACK),
    .DOUT(DOUT), .EXC(EXC), .DOV(DOV), .DOA(DOA),
    .ABUSY(ABUSY), .MBUSY(MBUSY), .DR(DR),
    .BUSY(BUSY), .STALE(STALE)
  );

  // FPU model: DACK after dack_dly extra DIV cycles, DOV dov_dly cycles after DACK.
  initial begin : fpu_model
    int ph;
    int cnt;
    logic dov_prev;
    ph = 0;
    cnt = 0;
    dov_prev = 1'b0;
    forever begin
      @(posedge CLK);
      #1;
      m_dack = 1'b0;
      m_dov  = 1'b0;
      if (DIV && (ph == 2 || dov_prev)) overlap_err++;
      dov_prev = 1'b0;
      if (!fpu_auto) begin
        ph = 0;
      end else begin
        case (ph)
          0: if (DIV) begin
               if (dack_dly == 0) begin
                 m_dack = 1'b1; issued++; ph = 2; cnt = 0;
               end else begin
                 cnt = 1; ph = 1;
               end
             end
          1: if (cnt == dack_dly) begin
               m_dack = 1'b1; issued++; ph = 2; cnt = 0;
             end else begin
               cnt++;
             end
          default: begin
            cnt++;
            if (cnt == dov_dly) begin
              m_dov  = 1'b1;
              m_dout = (resp_q.size() > 0) ? resp_q.pop_front() : 16'hDEAD;
              m_exc  = resp_exc;
              ph = 0;
              dov_prev = 1'b1;
            end
          end
        endcase
      end
    end
  end

  always @(negedge CLK) begin
    if (DIV) begin
      if (div_run > 0 && {DIN1, DIN2, OPT, MODE} !== div_fields) div_unstable++;
      div_fields = {DIN1, DIN2, OPT, MODE};
      div_run++;
    end else if (div_run > 0) begin
      last_div_run = div_run;
      div_run = 0;
    end
    if (DOA) begin
      doa_run++;
    end else if (doa_run > 0) begin
      last_doa_run = doa_run;
      doa_run = 0;
    end
    if (STALE) stale_cnt++;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", passed, total);
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_cmd(input logic [15:0] a, input logic [15:0] b,
                          input logic op, input logic [2:0] mode);
    int n;
    logic rdy;
    CMD_A = a; CMD_B = b; CMD_OP = op; CMD_MODE = mode; CMD_VALID = 1'b1;
    n = 0;
    do begin
      rdy = CMD_READY;
      if (!rdy) ready_low++;
      tick();
      n++;
    end while (!rdy && n < 50);
    CMD_VALID = 1'b0;
    if (!rdy) chk("push_cmd_stalled", CMD_READY, 1);
  endtask

  task automatic wait_res(input int budget, output int n);
    n = 0;
    while (!RES_VALID && n < budget) begin
      tick();
      n++;
    end
    if (n >= budget) chk("wait_res_expired", RES_VALID, 1);
  endtask

  task automatic pop_res();
    RES_READY = 1'b1;
    tick();
    RES_READY = 1'b0;
  endtask

  initial begin : stim
    int n;
    int got;
    int base;
    logic [15:0] rd [3];
    logic        ro [3];

    RSTn = 1'b0; CMD_VALID = 1'b0; CMD_A = '0; CMD_B = '0; CMD_OP = 1'b0; CMD_MODE = '0;
    RES_READY = 1'b0; ABUSY = 1'b0; MBUSY = 1'b0; DR = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_cs", CS, 0);
    chk("rst_div", DIV, 0);
    chk("rst_cmd_ready", CMD_READY, 0);
    chk("rst_res_valid", RES_VALID, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_din", {DIN1, DIN2}, 0);
    chk("rst_res_data", RES_DATA, 0);
    chk("rst_misc", {MODE, RES_EXC, OPT, DOA, STALE, RES_OP, RES_TIMEOUT}, 0);
    RSTn = 1'b1;
    tick();
    chk("post_rst_cs", CS, 1);
    chk("post_rst_cmd_ready", CMD_READY, 1);

    // Add, immediate DACK, DOV five cycles later
    fpu_auto = 1'b1; dack_dly = 0; dov_dly = 5; resp_exc = 3'b000;
    resp_q.push_back(16'h4200);
    push_cmd(16'h3C00, 16'h4000, 1'b0, 3'd2);
    chk("t1_div_n1", DIV, 0);
    chk("t1_busy", BUSY, 1);
    tick();
    chk("t1_div_n2", DIV, 1);
    chk("t1_din1", DIN1, 16'h3C00);
    chk("t1_din2", DIN2, 16'h4000);
    chk("t1_opt_mode", {OPT, MODE}, 4'b0010);
    wait_res(30, n);
    chk("t1_latency", n, 6);
    chk("t1_doa", DOA, 1);
    chk("t1_res", {RES_DATA, RES_EXC, RES_OP, RES_TIMEOUT}, {16'h4200, 3'b000, 1'b0, 1'b0});
    tick();
    chk("t1_doa_off", DOA, 0);
    chk("t1_div_run", last_div_run, 1);
    pop_res();
    chk("t1_doa_run", last_doa_run, 1);
    chk("t1_res_empty", RES_VALID, 0);
    chk("t1_idle", BUSY, 0);

    // Multiply, DACK held off three cycles
    dack_dly = 3; dov_dly = 2; resp_exc = 3'b001;
    resp_q.push_back(16'h4400);
    push_cmd(16'h4000, 16'h4200, 1'b1, 3'd0);
    tick();
    chk("t2_fields", {DIV, DIN1, DIN2, OPT}, {1'b1, 16'h4000, 16'h4200, 1'b1});
    wait_res(30, n);
    chk("t2_latency", n, 6);
    chk("t2_div_run", last_div_run, 4);
    chk("t2_div_stable", div_unstable, 0);
    chk("t2_res", {RES_DATA, RES_EXC, RES_OP, RES_TIMEOUT}, {16'h4400, 3'b001, 1'b1, 1'b0});
    pop_res();

    // Three back-to-back commands, results in order
    dack_dly = 0; dov_dly = 2; resp_exc = 3'b000;
    resp_q.push_back(16'h1111); resp_q.push_back(16'h2222); resp_q.push_back(16'h3333);
    RES_READY = 1'b1; ready_low = 0;
    push_cmd(16'h0001, 16'h0002, 1'b0, 3'd0);
    push_cmd(16'h0003, 16'h0004, 1'b1, 3'd0);
    push_cmd(16'h0005, 16'h0006, 1'b0, 3'd0);
    chk("t3_ready_high", ready_low, 0);
    got = 0; n = 0;
    while (got < 3 && n < 100) begin
      if (RES_VALID) begin
        rd[got] = RES_DATA; ro[got] = RES_OP; got++;
      end
      tick();
      n++;
    end
    chk("t3_count", got, 3);
    chk("t3_res0", {rd[0], ro[0]}, {16'h1111, 1'b0});
    chk("t3_res1", {rd[1], ro[1]}, {16'h2222, 1'b1});
    chk("t3_res2", {rd[2], ro[2]}, {16'h3333, 1'b0});
    chk("t3_no_overlap", overlap_err, 0);
    RES_READY = 1'b0;

    // Result FIFO full stalls issue
    base = issued;
    for (int i = 1; i <= 6; i++) resp_q.push_back(16'hA000 + 16'(i));
    for (int i = 0; i < 6; i++) push_cmd(16'h0100 + 16'(i), 16'h0200, 1'(i), 3'd1);
    repeat (60) tick();
    chk("t4_issued4", issued - base, 4);
    chk("t4_head", {RES_VALID, RES_DATA}, {1'b1, 16'hA001});
    chk("t4_div_low", DIV, 0);
    chk("t4_busy", BUSY, 1);
    pop_res();
    chk("t4_head2", RES_DATA, 16'hA002);
    repeat (20) tick();
    chk("t4_issued5", issued - base, 5);
    RES_READY = 1'b1;
    n = 0;
    while ((BUSY || RES_VALID) && n < 100) begin
      tick();
      n++;
    end
    RES_READY = 1'b0;
    chk("t4_issued6", issued - base, 6);
    chk("t4_drained", {BUSY, RES_VALID}, 0);
    chk("t4_no_overlap", overlap_err, 0);

    // FPU silent: timeout result, then a stray DOV in IDLE
    fpu_auto = 1'b0;
    push_cmd(16'h1234, 16'h5678, 1'b1, 3'd5);
    tick();
    chk("t5_div", DIV, 1);
    wait_res(50, n);
    chk("t5_latency", n, 20);
    chk("t5_res", {RES_DATA, RES_EXC, RES_OP, RES_TIMEOUT}, {16'h0000, 3'b000, 1'b1, 1'b1});
    chk("t5_no_doa", DOA, 0);
    pop_res();
    chk("t5_div_run", last_div_run, 20);
    man_dout = 16'h5555; man_dov = 1'b1;
    tick();
    man_dov = 1'b0;
    chk("t5_stale", {STALE, DOA, RES_VALID}, 3'b110);
    tick();
    chk("t5_stale_off", {STALE, DOA, RES_VALID, BUSY}, 4'b0000);

    // Reset during WAIT_RES with queued commands and a pending result
    fpu_auto = 1'b1; dack_dly = 0; dov_dly = 2;
    resp_q.push_back(16'hBEEF);
    push_cmd(16'h0A0A, 16'h0B0B, 1'b0, 3'd3);
    wait_res(30, n);
    dov_dly = 10;
    resp_q.push_back(16'hCAFE);
    push_cmd(16'h0C0C, 16'h0D0D, 1'b1, 3'd4);
    push_cmd(16'h0E0E, 16'h0F0F, 1'b0, 3'd4);
    push_cmd(16'h1010, 16'h1111, 1'b1, 3'd4);
    repeat (3) tick();
    chk("t6_pre", {DIV, BUSY, RES_VALID}, 3'b011);
    fpu_auto = 1'b0;
    RSTn = 1'b0;
    #1;
    chk("t6_ready_in_rst", CMD_READY, 0);
    tick();
    RSTn = 1'b1;
    #1;
    chk("t6_fpu_side", {CS, DIV, DOA, STALE, OPT, MODE}, 0);
    chk("t6_din", {DIN1, DIN2}, 0);
    chk("t6_res", {RES_VALID, RES_DATA, RES_EXC, RES_OP, RES_TIMEOUT}, 0);
    chk("t6_busy", BUSY, 0);
    chk("t6_cmd_ready", CMD_READY, 1);
    repeat (15) tick();
    chk("t6_discarded", {BUSY, RES_VALID, DIV}, 0);
    chk("t6_cs", CS, 1);
    chk("t6_stale_count", stale_cnt, 1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
